// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared size encodings, FSM states and lane-steering helpers for
//            the data-memory responder.
// Revision : 1.0
// ============================================================================
package dmem_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 4'b0001 << lo;
            SZ_H:    return 4'b0011 << {lo[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Low address bits that do not fit the size are simply ignored here.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  lo);
        case (sz)
            SZ_B:    return (word >> {lo, 3'b000}) & 32'h0000_00FF;
            SZ_H:    return (word >> {lo[1], 4'b0000}) & 32'h0000_FFFF;
            default: return word;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return 1'b0;
            SZ_H:    return lo[0];
            default: return (lo != 2'b00);
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : MEM-stage data bus between the pipeline and the data memory.
// Revision : 1.0
// ============================================================================
interface dmem_responder_if;
    logic        dreq;
    logic        dwrite;
    logic [31:0] daddr;
    logic [1:0]  dsize;
    logic [31:0] in_ddata;
    logic [31:0] out_ddata;
    logic        dready_n;
    logic        dbusy;
    logic        derr;

    modport master (
        output dreq, dwrite, daddr, dsize, in_ddata,
        input  out_ddata, dready_n, dbusy, derr
    );

    modport slave (
        input  dreq, dwrite, daddr, dsize, in_ddata,
        output out_ddata, dready_n, dbusy, derr
    );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Brief    : DEPTH x 32 word RAM, byte-enabled synchronous write,
//            asynchronous read at the same word index.
// Revision : 1.0
// ============================================================================
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [3:0]    i_be,
    input  wire logic [AW-1:0] i_idx,
    input  wire logic [31:0]   i_wdata,
    output logic      [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Wait-stated data-memory responder. Define DMEM_MISALIGN_TRAP_EN
//            to flag misaligned accesses with derr instead of forcing alignment.
// Revision : 1.0
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_responder_if.slave bus
);

    localparam int         c_AW   = $clog2(DEPTH);
    localparam logic [3:0] c_WAIT = 4'(WAIT_CYCLES);
    localparam logic [1:0] c_IDLE = IDLE;
    localparam logic [1:0] c_WST  = WAIT;
    localparam logic [1:0] c_RESP = RESP;

    logic [1:0]      r_state;
    logic [1:0]      w_nstate;
    logic [3:0]      r_cnt;
    logic            r_write;
    logic [c_AW+1:0] r_addr;
    logic [1:0]      r_size;
    logic [31:0]     r_wdata;

    logic            w_sel_in;
    logic            w_write;
    logic [c_AW+1:0] w_addr;
    logic [1:0]      w_size;
    logic [31:0]     w_wdata;
    logic [31:0]     w_rep;
    logic [31:0]     w_rdata;
    logic [31:0]     w_load;
    logic            w_misalign;
    logic            w_to_resp;
    logic            w_we;
    logic            w_unused_addr;

    assign w_unused_addr = ^bus.daddr[31:c_AW+2];

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            c_IDLE:  if (bus.dreq) w_nstate = (c_WAIT == 4'd0) ? c_RESP : c_WST;
            c_WST:   if (r_cnt <= 4'd1) w_nstate = c_RESP;
            c_RESP:  w_nstate = c_IDLE;
            default: w_nstate = c_IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the accept edge, so the
    // live bus values must steer the RAM while idle.
    assign w_sel_in = (r_state == c_IDLE);
    assign w_write  = w_sel_in ? bus.dwrite           : r_write;
    assign w_addr   = w_sel_in ? bus.daddr[c_AW+1:0]  : r_addr;
    assign w_size   = w_sel_in ? bus.dsize            : r_size;
    assign w_wdata  = w_sel_in ? bus.in_ddata         : r_wdata;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misalign = misaligned(w_size, w_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_comb begin
        case (w_size)
            SZ_B:    w_rep = {4{w_wdata[7:0]}};
            SZ_H:    w_rep = {2{w_wdata[15:0]}};
            default: w_rep = w_wdata;
        endcase
    end

    assign w_to_resp = (w_nstate == c_RESP);
    assign w_we      = w_to_resp && w_write && !w_misalign;
    assign w_load    = w_misalign ? 32'h0 : load_extract(w_rdata, w_size, w_addr[1:0]);

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (byte_en(w_size, w_addr[1:0])),
        .i_idx   (w_addr[c_AW+1:2]),
        .i_wdata (w_rep),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= c_IDLE;
            r_cnt         <= 4'd0;
            r_write       <= 1'b0;
            r_addr        <= '0;
            r_size        <= SZ_B;
            r_wdata       <= 32'h0;
            bus.dready_n  <= 1'b1;
            bus.dbusy     <= 1'b0;
            bus.out_ddata <= 32'h0;
            bus.derr      <= 1'b0;
        end else begin
            r_state <= w_nstate;
            if (r_state == c_IDLE && bus.dreq) begin
                r_cnt   <= c_WAIT;
                r_write <= bus.dwrite;
                r_addr  <= bus.daddr[c_AW+1:0];
                r_size  <= bus.dsize;
                r_wdata <= bus.in_ddata;
            end else if (r_state == c_WST) begin
                r_cnt <= r_cnt - 4'd1;
            end
            bus.dready_n  <= !w_to_resp;
            bus.dbusy     <= (w_nstate == c_WST);
            bus.out_ddata <= (w_to_resp && !w_write) ? w_load : 32'h0;
            bus.derr      <= w_to_resp && w_misalign;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder (2 and 0 wait states).
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_responder_if bA ();
    dmem_responder_if bB ();

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bA)
    );

    dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bB)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request on bus A; lat counts cycles from the accepting edge to dready_n low.
    task automatic txn(input bit wr, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d, output logic [31:0] rd, output bit er,
                       output int lat, output int busy);
        bit got;
        @(negedge clk);
        bA.dreq = 1'b1; bA.dwrite = wr; bA.daddr = a; bA.dsize = sz; bA.in_ddata = d;
        @(posedge clk);
        #1 bA.dreq = 1'b0;
        lat = 0; busy = 0; got = 1'b0; rd = 32'h0; er = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (bA.dbusy) busy++;
            if (!bA.dready_n) begin
                rd = bA.out_ddata; er = bA.derr; got = 1'b1;
            end
        end
        if (!got) lat = 99;
    endtask

    logic [31:0] rd;
    bit          er;
    int          lat, busy;
    logic [3:0]  pat;
    bit          b_busy;

    initial begin
        bA.dreq = 0; bA.dwrite = 0; bA.daddr = 0; bA.dsize = SZ_W; bA.in_ddata = 0;
        bB.dreq = 0; bB.dwrite = 0; bB.daddr = 0; bB.dsize = SZ_W; bB.in_ddata = 0;

        #2 rst = 1'b0;
        #1;
        chk("rst_dready_n", 32'(bA.dready_n), 32'h1);
        chk("rst_dbusy",    32'(bA.dbusy),    32'h0);
        chk("rst_out",      bA.out_ddata,     32'h0);
        chk("rst_derr",     32'(bA.derr),     32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        txn(1, 32'h10, SZ_W, 32'hDEADBEEF, rd, er, lat, busy);
        chk("sw_lat",  32'(lat),  32'd3);
        chk("sw_busy", 32'(busy), 32'd2);
        txn(0, 32'h10, SZ_W, 32'h0, rd, er, lat, busy);
        chk("lw_data", rd, 32'hDEADBEEF);
        chk("lw_lat",  32'(lat),  32'd3);
        chk("lw_busy", 32'(busy), 32'd2);
        chk("lw_derr", 32'(er),   32'h0);

        txn(1, 32'h13, SZ_B, 32'h000000AA, rd, er, lat, busy);
        txn(0, 32'h10, SZ_W, 32'h0, rd, er, lat, busy);
        chk("sb_merge", rd, 32'hAAADBEEF);
        txn(0, 32'h13, SZ_B, 32'h0, rd, er, lat, busy);
        chk("lbu", rd, 32'h000000AA);
        txn(0, 32'h12, SZ_H, 32'h0, rd, er, lat, busy);
        chk("lh", rd, 32'h0000AAAD);

        txn(1, 32'h1000, SZ_W, 32'h12345678, rd, er, lat, busy);
        txn(0, 32'h0, SZ_W, 32'h0, rd, er, lat, busy);
        chk("wrap_alias", rd, 32'h12345678);

        txn(1, 32'h20, SZ_W, 32'h0, rd, er, lat, busy);
        @(negedge clk);
        bA.dreq = 1'b1; bA.dwrite = 1'b1; bA.daddr = 32'h20; bA.dsize = SZ_W;
        bA.in_ddata = 32'hFFFFFFFF;
        @(posedge clk);
        #1 bA.dreq = 1'b0;
        @(negedge clk);
        chk("pre_abort_busy", 32'(bA.dbusy), 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_dbusy",    32'(bA.dbusy),    32'h0);
        chk("abort_dready_n", 32'(bA.dready_n), 32'h1);
        chk("abort_out",      bA.out_ddata,     32'h0);
        chk("abort_derr",     32'(bA.derr),     32'h0);
        @(negedge clk);
        rst = 1'b1;
        txn(0, 32'h20, SZ_W, 32'h0, rd, er, lat, busy);
        chk("abort_no_write", rd, 32'h0);

        txn(0, 32'h11, SZ_W, 32'h0, rd, er, lat, busy);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_lw_derr", 32'(er), 32'h1);
        chk("mis_lw_data", rd, 32'h0);
`else
        chk("mis_lw_derr", 32'(er), 32'h0);
        chk("mis_lw_data", rd, 32'hAAADBEEF);
`endif
        txn(1, 32'h11, SZ_W, 32'h55555555, rd, er, lat, busy);
        txn(0, 32'h10, SZ_W, 32'h0, rd, er, lat, busy);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_sw_ram", rd, 32'hAAADBEEF);
`else
        chk("mis_sw_ram", rd, 32'h55555555);
`endif

        // Zero wait states with dreq held: RESP, IDLE gap, RESP, IDLE.
        @(negedge clk);
        bB.dreq = 1'b1; bB.dwrite = 1'b1; bB.daddr = 32'h40; bB.dsize = SZ_W;
        bB.in_ddata = 32'h1;
        b_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pat[i] = bB.dready_n;
            if (bB.dbusy) b_busy = 1'b1;
            if (i == 2) bB.dreq = 1'b0;
        end
        chk("b2b_pattern", 32'(pat), 32'hA);
        chk("b2b_dbusy",   32'(b_busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
